// File: rtl/rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Width of one carry-chain chunk. A bad stage count yields the full width so
    // that elaboration reaches the parameter check instead of dividing by zero.
    function automatic int chunk_width(int width, int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// CW-bit ripple chain of 1-bit full adders: sum = a + b + cin, cout = carry out.
// Latency: purely combinational.
// Backpressure: none, no state.
module rca_chunk
    import rca_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    logic [CW:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[CW];

endmodule

// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry add/sub: one CW-bit carry chunk per stage, carries registered between.
// Latency: STAGES cycles from accept to out_valid; throughput 1 op/cycle.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready mirrors the advance enable.
module pipe_rca_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  op_e              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result,
    output logic             out_ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_param_check
        $error("pipe_rca_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Single enable for every stage: the pipe moves unless a result is stuck at the output.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction folds into the stage-0 operand: A - B = A + ~B + 1. After this point the
    // op is fully encoded in B' and the carry chain, so no later stage needs it.
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    assign cin0  = (in_op == OP_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * CW;      // sum bits already finished before this stage
        localparam int REM = WIDTH - LO;  // operand bits not yet consumed, this chunk at bit 0

        logic [REM-1:0]   a_i;
        logic [REM-1:0]   b_i;
        logic             c_i;
        logic             v_i;
        logic [CW-1:0]    s_chunk;
        logic             c_chunk;
        logic [LO+CW-1:0] s_i;            // finished low sum bits including this chunk

        if (k == 0) begin : g_src
            assign a_i = in_a;
            assign b_i = b_eff;
            assign c_i = cin0;
            assign v_i = in_valid;
            assign s_i = s_chunk;
        end else begin : g_src
            assign a_i = g_stage[k-1].g_reg.a_q;
            assign b_i = g_stage[k-1].g_reg.b_q;
            assign c_i = g_stage[k-1].g_reg.c_q;
            assign v_i = g_stage[k-1].g_reg.v_q;
            assign s_i = {s_chunk, g_stage[k-1].g_reg.s_q};
        end

        rca_chunk #(.CW(CW)) u_chunk (
            .a    (a_i[CW-1:0]),
            .b    (b_i[CW-1:0]),
            .cin  (c_i),
            .sum  (s_chunk),
            .cout (c_chunk)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [REM-CW-1:0] a_q;
            logic [REM-CW-1:0] b_q;
            logic [LO+CW-1:0]  s_q;
            logic              c_q;
            logic              v_q;

            // Hand the chunk carry, skewed low sum and unused upper operands to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= v_i;
                    c_q <= c_chunk;
                    a_q <= a_i[REM-1:CW];
                    b_q <= b_i[REM-1:CW];
                    s_q <= s_i;
                end
            end
        end else begin : g_out
            // Signed overflow: operands agree in sign but the sum does not.
            logic ovf;
            assign ovf = (a_i[CW-1] == b_i[CW-1]) && (s_chunk[CW-1] != a_i[CW-1]);

            // Output register; data only updates on a valid slot so bubbles never overwrite it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid  <= 1'b0;
                    out_result <= '0;
                    out_ovf    <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_i;
                    if (v_i) begin
                        out_result <= {c_chunk, s_i};
                        out_ovf    <= ovf;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Directed and randomised checks of pipe_rca_addsub in three shapes (8/2, 16/4, 8/1).
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_rca_addsub;
    import rca_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // WIDTH=8, STAGES=2: directed tests
    logic       v0, r0, ov0, or0, ovf0;
    logic [7:0] a0, b0;
    op_e        op0;
    logic [8:0] res0;

    // WIDTH=16, STAGES=4: random traffic
    logic        v1, r1, ov1, or1, ovf1;
    logic [15:0] a1, b1;
    op_e         op1;
    logic [16:0] res1;

    // WIDTH=8, STAGES=1: random traffic
    logic       v2, r2, ov2, or2, ovf2;
    logic [7:0] a2, b2;
    op_e        op2;
    logic [8:0] res2;

    pipe_rca_addsub #(.WIDTH(8), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0), .in_op(op0),
        .out_valid(ov0), .out_ready(or0), .out_result(res0), .out_ovf(ovf0)
    );

    pipe_rca_addsub #(.WIDTH(16), .STAGES(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_op(op1),
        .out_valid(ov1), .out_ready(or1), .out_result(res1), .out_ovf(ovf1)
    );

    pipe_rca_addsub #(.WIDTH(8), .STAGES(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2), .in_op(op2),
        .out_valid(ov2), .out_ready(or2), .out_result(res2), .out_ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, carry, sum} from a plain w-bit add of A, B' and cin.
    function automatic logic [17:0] model(input int w, input op_e op,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [16:0] mask, bp, full;
        logic        ovf;
        mask = (17'd1 << w) - 17'd1;
        bp   = (op == OP_SUB) ? ({1'b0, ~b} & mask) : {1'b0, b};
        full = {1'b0, a} + bp + ((op == OP_SUB) ? 17'd1 : 17'd0);
        ovf  = (a[w-1] == bp[w-1]) && (full[w-1] != a[w-1]);
        return {ovf, full};
    endfunction

    // One isolated op on the 8/2 instance: accepted now, invisible next cycle, present after two.
    task automatic do_op(input string tag, input op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] er, input logic eo);
        v0 = 1'b1; op0 = op; a0 = a; b0 = b; or0 = 1'b1;
        @(negedge clk); chk({tag, "_acc"}, 32'(r0), 32'(1));
        @(posedge clk); #1; v0 = 1'b0;
        @(negedge clk); chk({tag, "_lat"}, 32'(ov0), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_vld"}, 32'(ov0), 32'(1));
        chk({tag, "_res"}, 32'(res0), 32'(er));
        chk({tag, "_ovf"}, 32'(ovf0), 32'(eo));
        @(posedge clk); #1;
    endtask

    op_e         vop[4];
    logic [7:0]  va[4], vb[4];
    logic [8:0]  vr[4];
    logic        vo[4];
    int          sent, got;
    logic [17:0] q1[$], q2[$];
    logic        drive;

    initial begin
        rst = 1'b1;
        v0 = 1'b0; or0 = 1'b1; a0 = '0; b0 = '0; op0 = OP_ADD;
        v1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; op1 = OP_ADD;
        v2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; op2 = OP_ADD;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_vld", 32'(ov0), 32'(0));
        chk("rst_res", 32'(res0), 32'(0));
        chk("rst_ovf", 32'(ovf0), 32'(0));
        chk("rst_vld_b", 32'(ov1), 32'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("rst_in_ready", 32'(r0), 32'(1));
        @(posedge clk); #1;

        // Single ops: carry out, borrow, signed overflow corners
        do_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 9'h100, 1'b0);
        do_op("sub_05_07", OP_SUB, 8'h05, 8'h07, 9'h0FE, 1'b0);
        do_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 9'h17F, 1'b1);
        do_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 9'h080, 1'b1);
        do_op("add_80_80", OP_ADD, 8'h80, 8'h80, 9'h100, 1'b1);

        // Back-to-back ops with a 3-cycle consumer stall once the first result arrives
        vop = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB};
        va  = '{8'h10, 8'h30, 8'hC0, 8'h7F};
        vb  = '{8'h20, 8'h10, 8'h50, 8'hFF};
        vr  = '{9'h030, 9'h120, 9'h110, 9'h080};
        vo  = '{1'b0, 1'b0, 1'b0, 1'b1};
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            or0 = (cyc >= 5);
            v0  = (sent < 4);
            if (sent < 4) begin
                op0 = vop[sent]; a0 = va[sent]; b0 = vb[sent];
            end
            @(negedge clk);
            if (cyc >= 2 && cyc < 5) begin
                chk("stall_in_ready", 32'(r0), 32'(0));
                chk("stall_out_valid", 32'(ov0), 32'(1));
                chk("stall_hold_res", 32'(res0), 32'(vr[0]));
            end
            if (ov0 && or0) begin
                chk("order_res", 32'(res0), 32'(vr[got]));
                chk("order_ovf", 32'(ovf0), 32'(vo[got]));
                got++;
            end
            if (v0 && r0) sent++;
            @(posedge clk); #1;
        end
        v0 = 1'b0; or0 = 1'b1;
        chk("b2b_all_out", 32'(got), 32'(4));
        @(negedge clk); chk("b2b_no_dup", 32'(ov0), 32'(0));
        @(posedge clk); #1;

        // Reset with two ops in flight: one at the output, one in stage 0
        v0 = 1'b1; op0 = OP_ADD; a0 = 8'h11; b0 = 8'h22; or0 = 1'b0;
        @(posedge clk); #1; a0 = 8'h33; b0 = 8'h44;
        @(posedge clk); #1; v0 = 1'b0; rst = 1'b1;
        @(negedge clk); chk("rst_pre_vld", 32'(ov0), 32'(1));
        @(posedge clk); #1; rst = 1'b0; or0 = 1'b1;
        @(negedge clk);
        chk("rst_flush_vld", 32'(ov0), 32'(0));
        chk("rst_flush_res", 32'(res0), 32'(0));
        chk("rst_flush_ovf", 32'(ovf0), 32'(0));
        chk("rst_flush_rdy", 32'(r0), 32'(1));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk); chk("rst_no_stale", 32'(ov0), 32'(0));
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure on the 16/4 and 8/1 shapes
        for (int cyc = 0; cyc < 14000; cyc++) begin
            drive = (cyc < 13900);
            v1  = drive && ($urandom_range(0, 3) != 0);
            op1 = op_e'($urandom_range(0, 1));
            a1  = 16'($urandom);
            b1  = 16'($urandom);
            or1 = !drive || ($urandom_range(0, 3) != 0);
            v2  = drive && ($urandom_range(0, 3) != 0);
            op2 = op_e'($urandom_range(0, 1));
            a2  = 8'($urandom);
            b2  = 8'($urandom);
            or2 = !drive || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ov1 && or1) begin
                if (q1.size() == 0) chk("w16_spurious", 32'(ov1), 32'(0));
                else                chk("w16_res", 32'({ovf1, res1}), 32'(q1.pop_front()));
            end
            if (v1 && r1) q1.push_back(model(16, op1, a1, b1));
            if (ov2 && or2) begin
                if (q2.size() == 0) chk("w8s1_spurious", 32'(ov2), 32'(0));
                else                chk("w8s1_res", 32'({ovf2, 8'h00, res2}), 32'(q2.pop_front()));
            end
            if (v2 && r2) q2.push_back(model(8, op2, {8'h00, a2}, {8'h00, b2}));
            @(posedge clk); #1;
        end
        chk("w16_drained", 32'(q1.size()), 32'(0));
        chk("w8s1_drained", 32'(q2.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
